// File: rtl/read_stage_rr_arbiter_n.sv
// ---------------------------------------------------------------------------------------------
// read_stage_rr_arbiter_n
//
// N-way round-robin arbiter in front of one VRF read port. Each cycle it grants at most one of
// the NUM_IN requesters, starting the search just after the last granted channel. The granted
// request goes into a registered output entry ("main"). A second entry ("skid") absorbs one more
// accept when the output is stalled. Because of this, io_in_ready depends only on local state and
// the request valids, and never on io_out_ready.
//
// Ports
//   clock                        rising-edge clock for all state
//   reset                        asynchronous, active-low reset
//   io_in_valid[NUM_IN]          per-channel request valid
//   io_in_ready[NUM_IN]          per-channel accept, one-hot or zero
//   io_in_bits_*                 per-channel request fields; channel i sits at [i*W +: W]
//   io_out_ready                 downstream accept
//   io_out_valid                 output entry valid
//   io_out_bits_*                granted request fields, held stable while stalled
//   io_out_bits_grantIdx         channel that produced the output entry
// ---------------------------------------------------------------------------------------------
module read_stage_rr_arbiter_n #(
  parameter int unsigned NUM_IN   = 2,
  parameter int unsigned VS_W     = 5,
  parameter int unsigned OFFSET_W = 9,
  parameter int unsigned GROUP_W  = 4,
  parameter int unsigned SRC_W    = 4,
  parameter int unsigned INST_W   = 3,
  parameter int unsigned IDX_W    = $clog2(NUM_IN)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_IN-1:0]          io_in_valid,
  output logic [NUM_IN-1:0]          io_in_ready,
  input  logic [NUM_IN*VS_W-1:0]     io_in_bits_vs,
  input  logic [NUM_IN*OFFSET_W-1:0] io_in_bits_offset,
  input  logic [NUM_IN*GROUP_W-1:0]  io_in_bits_groupIndex,
  input  logic [NUM_IN*SRC_W-1:0]    io_in_bits_readSource,
  input  logic [NUM_IN*INST_W-1:0]   io_in_bits_instructionIndex,
  input  logic                       io_out_ready,
  output logic                       io_out_valid,
  output logic [VS_W-1:0]            io_out_bits_vs,
  output logic [OFFSET_W-1:0]        io_out_bits_offset,
  output logic [GROUP_W-1:0]         io_out_bits_groupIndex,
  output logic [SRC_W-1:0]           io_out_bits_readSource,
  output logic [INST_W-1:0]          io_out_bits_instructionIndex,
  output logic [IDX_W-1:0]           io_out_bits_grantIdx
);

  typedef struct packed {
    logic [VS_W-1:0]     vs;
    logic [OFFSET_W-1:0] offset;
    logic [GROUP_W-1:0]  group_index;
    logic [SRC_W-1:0]    read_source;
    logic [INST_W-1:0]   instruction_index;
    logic [IDX_W-1:0]    grant_idx;
  } payload_t;

  // Control state
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;

  // Payload state, never reset
  payload_t         main_q, main_d;
  payload_t         skid_q, skid_d;

  // Arbitration results
  logic [IDX_W-1:0] sel;
  logic             any_valid;
  logic             can_accept;
  logic             fire_in;
  logic             fire_out;
  payload_t         in_pay;

  // -------------------------------------------------------------------------------------------
  // Round-robin search: ptr+1, ptr+2, ... wrapping at NUM_IN. The first valid channel wins.
  // The candidate index has one extra bit so that ptr+k cannot overflow before the wrap.
  // -------------------------------------------------------------------------------------------
  always_comb begin
    logic [IDX_W:0] cand;
    cand      = '0;
    sel       = ptr_q;
    any_valid = 1'b0;
    for (int k = 1; k <= int'(NUM_IN); k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_IN)) begin
        cand = cand - (IDX_W+1)'(NUM_IN);
      end
      if (!any_valid && io_in_valid[cand[IDX_W-1:0]]) begin
        sel       = cand[IDX_W-1:0];
        any_valid = 1'b1;
      end
    end
  end

  // While reset is held, nothing may be accepted, because the accept would be lost on release.
  assign can_accept = reset & ~skid_valid_q;

  always_comb begin
    io_in_ready = '0;
    if (can_accept && any_valid) begin
      io_in_ready[sel] = 1'b1;
    end
  end

  assign fire_in  = |io_in_ready;
  assign fire_out = main_valid_q & io_out_ready;

  // Field mux for the winning channel
  always_comb begin
    in_pay.vs                = io_in_bits_vs[sel*VS_W +: VS_W];
    in_pay.offset            = io_in_bits_offset[sel*OFFSET_W +: OFFSET_W];
    in_pay.group_index       = io_in_bits_groupIndex[sel*GROUP_W +: GROUP_W];
    in_pay.read_source       = io_in_bits_readSource[sel*SRC_W +: SRC_W];
    in_pay.instruction_index = io_in_bits_instructionIndex[sel*INST_W +: INST_W];
    in_pay.grant_idx         = sel;
  end

  // -------------------------------------------------------------------------------------------
  // Storage next-state.
  // When main frees up (empty, or drained this cycle), main refills from the skid entry first,
  // so the older entry always leaves first. A new accept can only go straight into main when
  // the skid entry is empty, and can_accept already enforces that.
  // -------------------------------------------------------------------------------------------
  always_comb begin
    ptr_d        = fire_in ? sel : ptr_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;

    if (!main_valid_q || fire_out) begin
      main_valid_d = skid_valid_q | fire_in;
      if (skid_valid_q) begin
        main_d = skid_q;
      end else if (fire_in) begin
        main_d = in_pay;
      end
      skid_valid_d = 1'b0;
    end else if (fire_in) begin
      skid_valid_d = 1'b1;
      skid_d       = in_pay;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q        <= IDX_W'(NUM_IN - 1);
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  always_ff @(posedge clock) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

  // Outputs
  assign io_out_valid                 = main_valid_q;
  assign io_out_bits_vs               = main_q.vs;
  assign io_out_bits_offset           = main_q.offset;
  assign io_out_bits_groupIndex       = main_q.group_index;
  assign io_out_bits_readSource       = main_q.read_source;
  assign io_out_bits_instructionIndex = main_q.instruction_index;
  assign io_out_bits_grantIdx         = main_q.grant_idx;

`ifndef SYNTHESIS
  ready_onehot_a : assert property (@(posedge clock) disable iff (!reset)
    $onehot0(io_in_ready));

  ready_needs_valid_a : assert property (@(posedge clock) disable iff (!reset)
    (io_in_ready & ~io_in_valid) == '0);

  out_stable_a : assert property (@(posedge clock) disable iff (!reset)
    (io_out_valid && !io_out_ready) |=> (io_out_valid && $stable(main_q)));
`endif

endmodule

// File: tb/tb_read_stage_rr_arbiter_n.sv
// ---------------------------------------------------------------------------------------------
// Testbench for read_stage_rr_arbiter_n with NUM_IN=4.
// It applies a table of single-cycle vectors, a few hand-written stall and reset sequences, and
// a randomized run that is checked against a scoreboard.
// ---------------------------------------------------------------------------------------------
module tb_read_stage_rr_arbiter_n;

  localparam int unsigned N        = 4;
  localparam int unsigned VS_W     = 5;
  localparam int unsigned OFFSET_W = 9;
  localparam int unsigned GROUP_W  = 4;
  localparam int unsigned SRC_W    = 4;
  localparam int unsigned INST_W   = 3;
  localparam int unsigned IDX_W    = 2;
  localparam int          NVEC     = 20;

  typedef struct packed {
    logic [4:0] vs;
    logic [8:0] off;
    logic [3:0] grp;
    logic [3:0] src;
    logic [2:0] inst;
    logic [1:0] gi;
  } pay_t;

  typedef struct {
    logic [3:0] v;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] gi;
  } vec_t;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic [N-1:0]          in_valid;
  logic [N-1:0]          in_ready;
  logic [N*VS_W-1:0]     in_vs;
  logic [N*OFFSET_W-1:0] in_off;
  logic [N*GROUP_W-1:0]  in_grp;
  logic [N*SRC_W-1:0]    in_src;
  logic [N*INST_W-1:0]   in_inst;
  logic                  out_ready;
  logic                  out_valid;
  logic [VS_W-1:0]       out_vs;
  logic [OFFSET_W-1:0]   out_off;
  logic [GROUP_W-1:0]    out_grp;
  logic [SRC_W-1:0]      out_src;
  logic [INST_W-1:0]     out_inst;
  logic [IDX_W-1:0]      out_gi;
  pay_t                  out_pay;

  pay_t ch [N];
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  read_stage_rr_arbiter_n #(
    .NUM_IN  (N),
    .VS_W    (VS_W),
    .OFFSET_W(OFFSET_W),
    .GROUP_W (GROUP_W),
    .SRC_W   (SRC_W),
    .INST_W  (INST_W),
    .IDX_W   (IDX_W)
  ) dut (
    .clock                       (clock),
    .reset                       (reset),
    .io_in_valid                 (in_valid),
    .io_in_ready                 (in_ready),
    .io_in_bits_vs               (in_vs),
    .io_in_bits_offset           (in_off),
    .io_in_bits_groupIndex       (in_grp),
    .io_in_bits_readSource       (in_src),
    .io_in_bits_instructionIndex (in_inst),
    .io_out_ready                (out_ready),
    .io_out_valid                (out_valid),
    .io_out_bits_vs              (out_vs),
    .io_out_bits_offset          (out_off),
    .io_out_bits_groupIndex      (out_grp),
    .io_out_bits_readSource      (out_src),
    .io_out_bits_instructionIndex(out_inst),
    .io_out_bits_grantIdx        (out_gi)
  );

  always_comb begin
    in_vs   = '0;
    in_off  = '0;
    in_grp  = '0;
    in_src  = '0;
    in_inst = '0;
    for (int i = 0; i < int'(N); i++) begin
      in_vs[i*VS_W +: VS_W]             = ch[i].vs;
      in_off[i*OFFSET_W +: OFFSET_W]    = ch[i].off;
      in_grp[i*GROUP_W +: GROUP_W]      = ch[i].grp;
      in_src[i*SRC_W +: SRC_W]          = ch[i].src;
      in_inst[i*INST_W +: INST_W]       = ch[i].inst;
    end
  end

  assign out_pay = {out_vs, out_off, out_grp, out_src, out_inst, out_gi};

  function automatic pay_t def_pay(input int i);
    pay_t p;
    p.vs   = 5'(i * 7 + 1);
    p.off  = 9'(i * 37 + 5);
    p.grp  = 4'(i + 2);
    p.src  = 4'(9 - i);
    p.inst = 3'(i + 1);
    p.gi   = 2'(i);
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  // Random phase state
  pay_t       sb_q [$];
  int         wait_cnt [N];
  logic [N-1:0] granted;
  logic       hold_pending;
  pay_t       held;
  pay_t       exp_pay;

  initial begin
    for (int i = 0; i < int'(N); i++) ch[i] = def_pay(i);
    in_valid  = '1;
    out_ready = 1'b1;

    // Vectors: {valid, out_ready, expected ready, expected out_valid, expected grantIdx}
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    vecs[6]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd1};
    vecs[7]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[8]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[9]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[10] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[11] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd2};
    vecs[12] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd3};
    vecs[13] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd1};
    vecs[14] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3};
    vecs[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[16] = '{4'b0110, 1'b1, 4'b0010, 1'b0, 2'd0};
    vecs[17] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd1};
    vecs[18] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd2};
    vecs[19] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};

    // Reset state: nothing valid out and nothing accepted while reset is held
    #3;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Table phase
    for (int t = 0; t < NVEC; t++) begin
      in_valid  = vecs[t].v;
      out_ready = vecs[t].ordy;
      #1;
      check($sformatf("vec%0d in_ready", t), 64'(in_ready), 64'(vecs[t].rdy));
      check($sformatf("vec%0d out_valid", t), 64'(out_valid), 64'(vecs[t].ov));
      if (vecs[t].ov) begin
        check($sformatf("vec%0d out_bits", t), 64'(out_pay), 64'(def_pay(int'(vecs[t].gi))));
      end
      @(negedge clock);
    end

    // Stall: two accepts fill main and skid, after which in_ready drops and the output holds
    ch[0].vs  = 5'h1F;
    ch[0].off = 9'h1AB;
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    #1;
    check("stall acc1 ready", 64'(in_ready), 64'b0001);
    check("stall acc1 out_valid", 64'(out_valid), 64'd0);
    @(negedge clock);
    ch[0].vs  = 5'h0A;
    ch[0].off = 9'h055;
    #1;
    check("stall acc2 ready", 64'(in_ready), 64'b0001);
    check("stall acc2 out_vs", 64'({out_valid, out_vs, out_off}), 64'({1'b1, 5'h1F, 9'h1AB}));
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      #1;
      check("stall full ready", 64'(in_ready), 64'd0);
      check("stall hold out", 64'({out_valid, out_vs, out_off}), 64'({1'b1, 5'h1F, 9'h1AB}));
    end
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    #1;
    check("drain first", 64'({out_valid, out_vs, out_off}), 64'({1'b1, 5'h1F, 9'h1AB}));
    @(negedge clock);
    #1;
    check("drain second", 64'({out_valid, out_vs, out_off}), 64'({1'b1, 5'h0A, 9'h055}));
    @(negedge clock);
    #1;
    check("drain empty", 64'(out_valid), 64'd0);
    ch[0] = def_pay(0);

    // Reset with both entries full; ptr is 0 here
    @(negedge clock);
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    #1;
    check("rst fill1 ready", 64'(in_ready), 64'b0010);
    @(negedge clock);
    #1;
    check("rst fill2 ready", 64'(in_ready), 64'b0100);
    @(negedge clock);
    #1;
    check("rst full ready", 64'(in_ready), 64'd0);
    check("rst full out", 64'({out_valid, out_gi}), 64'({1'b1, 2'd1}));
    #1;
    reset = 1'b0;
    #1;
    check("rst async out_valid", 64'(out_valid), 64'd0);
    check("rst async ready", 64'(in_ready), 64'd0);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("rst release ready", 64'(in_ready), 64'b0001);
    check("rst release out_valid", 64'(out_valid), 64'd0);
    @(negedge clock);
    out_ready = 1'b1;
    #1;
    check("rst first grant", 64'({out_valid, out_gi}), 64'({1'b1, 2'd0}));
    check("rst second ready", 64'(in_ready), 64'b0010);
    in_valid = '0;
    @(negedge clock);
    @(negedge clock);

    // Random phase with scoreboard
    sb_q.delete();
    granted      = '0;
    hold_pending = 1'b0;
    held         = '0;
    for (int i = 0; i < int'(N); i++) begin
      wait_cnt[i] = 0;
      ch[i]       = def_pay(i);
      ch[i].vs    = 5'(i);
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (granted[i]) begin
          ch[i].off  = ch[i].off + 9'd1;
          ch[i].grp  = 4'($urandom_range(0, 15));
          ch[i].src  = 4'($urandom_range(0, 15));
          ch[i].inst = 3'($urandom_range(0, 7));
          in_valid[i] = ($urandom_range(0, 2) != 0);
        end else if (in_valid[i]) begin
          if ($urandom_range(0, 19) == 0) in_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          in_valid[i] = 1'b1;
        end
      end
      granted   = '0;
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      check("rand ready legal",
            64'($onehot0(in_ready) && ((in_ready & ~in_valid) == '0)), 64'd1);
      if (hold_pending) begin
        check("rand hold stable", 64'({out_valid, out_pay}), 64'({1'b1, held}));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("rand spurious out", 64'(out_valid), 64'd0);
        end else begin
          exp_pay = sb_q.pop_front();
          check("rand order", 64'(out_pay), 64'(exp_pay));
        end
      end
      hold_pending = out_valid && !out_ready;
      held         = out_pay;
      for (int j = 0; j < int'(N); j++) begin
        if (in_ready[j]) begin
          exp_pay    = ch[j];
          exp_pay.gi = 2'(j);
          sb_q.push_back(exp_pay);
          check($sformatf("rand fair ch%0d", j), 64'(wait_cnt[j] <= int'(N) - 1), 64'd1);
          granted[j] = 1'b1;
        end
      end
      for (int i = 0; i < int'(N); i++) begin
        if (!in_valid[i] || granted[i]) wait_cnt[i] = 0;
        else if (|in_ready) wait_cnt[i]++;
      end
      @(negedge clock);
    end

    // Drain remaining entries
    in_valid  = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("drain spurious out", 64'(out_valid), 64'd0);
        end else begin
          exp_pay = sb_q.pop_front();
          check("drain order", 64'(out_pay), 64'(exp_pay));
        end
      end
      @(negedge clock);
    end
    check("scoreboard empty", 64'(sb_q.size()), 64'd0);
    check("final out_valid", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
